dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  N  64  data and address width
  DEPTH  64  array size in doublewords; index = address[8:3]
  WB_DEPTH  4  posted-write buffer entries
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning (clock and reset first).
  clk  in  1  single clock; all state updates on rising edge
  reset  in  1  synchronous, active-high
  memRead  in  1  load request this cycle
  memWrite  in  1  store request this cycle
  address  in  N  byte address of access
  writeData  in  N  store data
  readData  out  N  load data, same cycle (combinational)
  wbuf_count  out  3  posted-write buffer occupancy, 0..WB_DEPTH
  wbuf_empty  out  1  wbuf_count==0
  err  out  1  sticky access-error flag
REQ-003 The block SHALL have one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 Word index SHALL be address[8:3]; upper bits ignored (modulo-DEPTH wrap); misaligned = address[2:0]!=0.
REQ-005 Aligned store (memWrite=1, memRead=0) SHALL enqueue {index, writeData} at the tail at the next edge.
REQ-006 Drain: head entry SHALL be written to the array and popped at the edge when buffer non-empty AND (memRead=0 AND memWrite=0, OR buffer full AND store accepted).
REQ-007 Full + store SHALL drain head and enqueue simultaneously; wbuf_count stays WB_DEPTH; no overflow, no store lost.
REQ-008 Aligned load (memRead=1, memWrite=0) SHALL return the youngest buffer entry whose index matches, else array[index], in the same cycle; no drain that cycle.
REQ-009 readData SHALL be 0 when memRead=0 or the load is misaligned.
REQ-010 Misaligned access SHALL be ignored (no enqueue, no array change) and set err at the next edge.
REQ-011 memRead=1 AND memWrite=1 SHALL be treated as the store only, readData=0, and set err.
REQ-012 err SHALL stay 1 until reset; wbuf_count SHALL change by at most 1 per cycle.

Reset
REQ-013 reset SHALL empty the buffer (wbuf_count=0, wbuf_empty=1), clear err, and discard undrained entries, with priority over any same-cycle access.
REQ-014 reset SHALL NOT modify array contents; readData follows REQ-008/009 combinationally during reset.

Structure
REQ-015 Package dmem_pkg SHALL hold N, DEPTH, WB_DEPTH, the index width constant and typedef wb_entry_t {index, data}.
REQ-016 Buffer SHALL be sub-module wbuf_fifo (circular, head/tail pointers, count, push/pop, parallel entry view for forwarding); dmem_responder holds array, forwarding, drain control, err.

Verification
REQ-017 Store 0xAA at 0x10, load 0x10 next cycle -> readData=0xAA from buffer, wbuf_count=1; one idle cycle -> count=0, load 0x10 -> 0xAA from array.
REQ-018 Five back-to-back stores 0x00..0x20 data 1..5 -> count 1,2,3,4,4; word 0x00 in array after 5th edge; loads return 1..5.
REQ-019 Stores to 0x08 of 7 then 9, load 0x08 -> readData=9 (youngest match).
REQ-020 Store to 0x0C -> err=1, count unchanged; load 0x0C -> readData=0.
REQ-021 Three stores then reset for one cycle -> count=0, err=0, array unchanged at those addresses.
REQ-022 memRead=memWrite=1 at 0x18 data 0x5 -> readData=0, err=1, later load 0x18 -> 0x5.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and posted-write entry type for dmem_responder
package dmem_pkg;
    localparam int N        = 64;
    localparam int DEPTH    = 64;
    localparam int WB_DEPTH = 4;
    localparam int IDX_W    = $clog2(DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [N-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/wbuf_fifo.sv
// rtl/wbuf_fifo.sv - circular posted-write buffer with an oldest-first view of live entries
module wbuf_fifo
    import dmem_pkg::*;
#(
    parameter int ENTRIES = WB_DEPTH,
    parameter int CNT_W   = $clog2(ENTRIES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  wb_entry_t          push_entry,
    output wb_entry_t          head_entry,
    output wb_entry_t          view [ENTRIES],
    output logic [ENTRIES-1:0] view_valid,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               full
);
    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    wb_entry_t        slots_q [ENTRIES];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (reset) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        if (!reset && push) slots_q[tail_q] <= push_entry;
    end

    // view[0] is the oldest entry, view[count-1] the youngest
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            view[i]       = slots_q[PTR_W'((int'(head_q) + i) % ENTRIES)];
            view_valid[i] = (CNT_W'(i) < count_q);
        end
    end

    assign head_entry = slots_q[head_q];
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(ENTRIES));
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data memory with posted-write buffer, load forwarding and sticky error
module dmem_responder #(
    parameter int N        = dmem_pkg::N,
    parameter int DEPTH    = dmem_pkg::DEPTH,
    parameter int WB_DEPTH = dmem_pkg::WB_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memRead,
    input  logic         memWrite,
    input  logic [N-1:0] address,
    input  logic [N-1:0] writeData,
    output logic [N-1:0] readData,
    output logic [2:0]   wbuf_count,
    output logic         wbuf_empty,
    output logic         err
);
    import dmem_pkg::*;

    logic             aligned, idle, store_acc, load_acc;
    logic             do_push, do_pop;
    logic [IDX_W-1:0] idx;
    wb_entry_t        push_entry, head_entry;
    wb_entry_t        view [WB_DEPTH];
    logic [WB_DEPTH-1:0] view_valid;
    logic             wb_full, wb_empty_int;
    logic [2:0]       count_int;
    logic [N-1:0]     mem_q [DEPTH];
    logic             err_q, err_d;
    logic             unused_addr;

    assign unused_addr = ^address[N-1:IDX_W+3];

    always_comb begin
        aligned   = (address[2:0] == 3'b000);
        idx       = address[IDX_W+2:3];
        idle      = !memRead && !memWrite;
        store_acc = memWrite && aligned;
        load_acc  = memRead && !memWrite && aligned;
        do_push   = store_acc && !reset;
        // a store into a full buffer retires the head in the same edge
        do_pop    = !wb_empty_int && !reset && (idle || (wb_full && store_acc));
        push_entry = '{index: idx, data: writeData};
    end

    wbuf_fifo #(
        .ENTRIES (WB_DEPTH),
        .CNT_W   (3)
    ) u_wbuf (
        .clk        (clk),
        .reset      (reset),
        .push       (do_push),
        .pop        (do_pop),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .view       (view),
        .view_valid (view_valid),
        .count      (count_int),
        .empty      (wb_empty_int),
        .full       (wb_full)
    );

    // later (younger) matches override earlier ones
    always_comb begin
        readData = '0;
        if (load_acc) begin
            readData = mem_q[idx];
            for (int i = 0; i < WB_DEPTH; i++) begin
                if (view_valid[i] && view[i].index == idx) readData = view[i].data;
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if ((memRead || memWrite) && !aligned) err_d = 1'b1;
        if (memRead && memWrite)               err_d = 1'b1;
        if (reset)                             err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        err_q <= err_d;
        if (do_pop) mem_q[head_entry.index] <= head_entry.data;
    end

    assign wbuf_count = count_int;
    assign wbuf_empty = wb_empty_int;
    assign err        = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;
    logic        clk, reset, memRead, memWrite;
    logic [63:0] address, writeData, readData;
    logic [2:0]  wbuf_count;
    logic        wbuf_empty, err;

    dmem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .address    (address),
        .writeData  (writeData),
        .readData   (readData),
        .wbuf_count (wbuf_count),
        .wbuf_empty (wbuf_empty),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [5:0]  idx;
        logic [63:0] data;
    } ent_t;

    logic [63:0] m_mem [64];
    ent_t        m_q [$];
    bit          m_err;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] rd_obs;
    logic [63:0] old_a, old_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input bit rd, input bit wr, input logic [63:0] addr);
        logic [5:0] i6;
        i6 = addr[8:3];
        if (!rd || wr || addr[2:0] != 3'b000) return 64'h0;
        for (int i = m_q.size() - 1; i >= 0; i--)
            if (m_q[i].idx == i6) return m_q[i].data;
        return m_mem[i6];
    endfunction

    function automatic logic [63:0] mk_addr(input int index, input bit mis);
        logic [63:0] a;
        logic [5:0]  i6;
        i6 = index[5:0];
        a = {$urandom, $urandom};
        a[8:3] = i6;
        a[2:0] = mis ? 3'($urandom_range(1, 7)) : 3'b000;
        return a;
    endfunction

    task automatic step(input bit rst, input bit rd, input bit wr,
                        input logic [63:0] addr, input logic [63:0] data);
        bit   al, st;
        ent_t e;
        @(negedge clk);
        reset = rst; memRead = rd; memWrite = wr; address = addr; writeData = data;
        #1;
        rd_obs = readData;
        check("readData", readData, model_read(rd, wr, addr));
        if (rst) begin
            m_q.delete();
            m_err = 1'b0;
        end else begin
            al = (addr[2:0] == 3'b000);
            st = wr && al;
            if (((rd || wr) && !al) || (rd && wr)) m_err = 1'b1;
            if (m_q.size() > 0 && ((!rd && !wr) || (m_q.size() == 4 && st))) begin
                e = m_q.pop_front();
                m_mem[e.idx] = e.data;
            end
            if (st) begin
                e.idx = addr[8:3];
                e.data = data;
                m_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check("wbuf_count", 64'(wbuf_count), 64'(m_q.size()));
        check("wbuf_empty", 64'(wbuf_empty), 64'(m_q.size() == 0));
        check("err", 64'(err), 64'(m_err));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    initial begin
        int  op, index;
        bit  rst, rd, wr, mis;
        reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; address = '0; writeData = '0;
        m_err = 1'b0;
        for (int i = 0; i < 64; i++) m_mem[i] = 64'h0;

        step(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        check("reset_count", 64'(wbuf_count), 64'd0);
        check("reset_empty", 64'(wbuf_empty), 64'd1);
        check("reset_err", 64'(err), 64'd0);

        for (int i = 0; i < 64; i++)
            step(1'b0, 1'b0, 1'b1, mk_addr(i, 1'b0), {$urandom, $urandom});
        idle(4);

        step(1'b0, 1'b0, 1'b1, 64'h10, 64'hAA);
        step(1'b0, 1'b1, 1'b0, 64'h10, 64'h0);
        check("fwd_data", rd_obs, 64'hAA);
        check("fwd_count", 64'(wbuf_count), 64'd1);
        idle(1);
        check("drain_count", 64'(wbuf_count), 64'd0);
        step(1'b0, 1'b1, 1'b0, 64'h10, 64'h0);
        check("array_data", rd_obs, 64'hAA);

        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 64'(i * 8), 64'(i + 1));
            check("b2b_count", 64'(wbuf_count), 64'((i < 4) ? i + 1 : 4));
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 64'(i * 8), 64'h0);
            check("b2b_load", rd_obs, 64'(i + 1));
        end

        step(1'b0, 1'b0, 1'b1, 64'h08, 64'd7);
        step(1'b0, 1'b0, 1'b1, 64'h08, 64'd9);
        step(1'b0, 1'b1, 1'b0, 64'h08, 64'h0);
        check("youngest", rd_obs, 64'd9);

        idle(4);
        old_a = m_mem[8];
        old_b = m_mem[10];
        step(1'b0, 1'b0, 1'b1, 64'h40, 64'h1111);
        step(1'b0, 1'b0, 1'b1, 64'h48, 64'h2222);
        step(1'b0, 1'b0, 1'b1, 64'h50, 64'h3333);
        step(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        check("rst_count", 64'(wbuf_count), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        step(1'b0, 1'b1, 1'b0, 64'h40, 64'h0);
        check("rst_keep_a", rd_obs, old_a);
        step(1'b0, 1'b1, 1'b0, 64'h50, 64'h0);
        check("rst_keep_b", rd_obs, old_b);

        step(1'b0, 1'b0, 1'b1, 64'h0C, 64'h33);
        check("mis_err", 64'(err), 64'd1);
        check("mis_count", 64'(wbuf_count), 64'd0);
        step(1'b0, 1'b1, 1'b0, 64'h0C, 64'h0);
        check("mis_load", rd_obs, 64'h0);

        step(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        step(1'b0, 1'b1, 1'b1, 64'h18, 64'h5);
        check("both_rd", rd_obs, 64'h0);
        check("both_err", 64'(err), 64'd1);
        idle(4);
        step(1'b0, 1'b1, 1'b0, 64'h18, 64'h0);
        check("both_store", rd_obs, 64'h5);

        for (int c = 0; c < 1000; c++) begin
            rst   = ($urandom_range(0, 99) < 2);
            op    = $urandom_range(0, 99);
            rd    = (op >= 30 && op < 65) || op >= 95;
            wr    = op >= 65;
            mis   = ($urandom_range(0, 9) == 0);
            index = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 63);
            step(rst, rd, wr, mk_addr(index, mis), {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
